demux_stream: RTL and testbench



---
 rtl/demux_stream_if.sv | 40 ++++
 rtl/demux_stream.sv | 75 +++++++
 tb/tb_demux_stream.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/demux_stream_if.sv
// Handshake bundle for demux_stream: one input stream in, four output streams out.
// The delivered-beat counters appear only when DEMUX_CNT_EN is defined.
interface demux_stream_if #(
  parameter int W = 3
);
  logic [W-1:0] i;
  logic [1:0]   sel;
  logic         i_valid;
  logic         i_ready;
  logic [W-1:0] y0;
  logic [W-1:0] y1;
  logic [W-1:0] y2;
  logic [W-1:0] y3;
  logic [3:0]   y_valid;
  logic [3:0]   y_ready;
`ifdef DEMUX_CNT_EN
  logic [7:0]   cnt0;
  logic [7:0]   cnt1;
  logic [7:0]   cnt2;
  logic [7:0]   cnt3;
`endif

  // Producer/consumer side (the environment driving the demux)
  modport master (
    output i, sel, i_valid, y_ready,
    input  i_ready, y0, y1, y2, y3, y_valid
`ifdef DEMUX_CNT_EN
    , input cnt0, cnt1, cnt2, cnt3
`endif
  );

  // The demux itself
  modport slave (
    input  i, sel, i_valid, y_ready,
    output i_ready, y0, y1, y2, y3, y_valid
`ifdef DEMUX_CNT_EN
    , output cnt0, cnt1, cnt2, cnt3
`endif
  );
endinterface

// File: rtl/demux_stream.sv
// Registered 1-to-4 stream demultiplexer, one holding register per output.
// Optional delivered-beat counters are enabled by defining DEMUX_CNT_EN.
module demux_stream #(
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           rst,
  demux_stream_if.slave  s
);
  logic [3:0]   r_full;
  logic [W-1:0] r_data [4];
  logic [3:0]   w_load;
  logic [3:0]   w_drain;
  logic         w_ready;

  // A destination can take a beat when empty, or when its beat leaves this cycle.
  assign w_ready   = ~r_full[s.sel] | s.y_ready[s.sel];
  assign s.i_ready = w_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_out
      assign w_load[gi]  = s.i_valid & w_ready & (s.sel == 2'(gi));
      assign w_drain[gi] = r_full[gi] & s.y_ready[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_load[k]) begin
          // load wins over drain so a drain+load keeps the slot full
          r_data[k] <= s.i;
          r_full[k] <= 1'b1;
        end else if (w_drain[k]) begin
          r_full[k] <= 1'b0;
        end
      end
    end
  end

  assign s.y_valid = r_full;
  assign s.y0      = r_data[0];
  assign s.y1      = r_data[1];
  assign s.y2      = r_data[2];
  assign s.y3      = r_data[3];

`ifdef DEMUX_CNT_EN
  logic [7:0] r_cnt [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        r_cnt[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_drain[k]) begin
          r_cnt[k] <= r_cnt[k] + 8'd1;
        end
      end
    end
  end

  assign s.cnt0 = r_cnt[0];
  assign s.cnt1 = r_cnt[1];
  assign s.cnt2 = r_cnt[2];
  assign s.cnt3 = r_cnt[3];
`endif
endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed scenarios plus randomized traffic
// checked against a per-destination queue model.
module tb_demux_stream;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_stream_if #(.W(W)) bus ();
  demux_stream #(.W(W)) dut (.clk(clk), .rst(rst), .s(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: beats not yet delivered per destination, last value seen per output.
  logic [W-1:0] mq [4][$];
  logic [W-1:0] last_d [4];
  int           mcnt [4];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] get_y(input int k);
    case (k)
      0: get_y = bus.y0;
      1: get_y = bus.y1;
      2: get_y = bus.y2;
      default: get_y = bus.y3;
    endcase
  endfunction

`ifdef DEMUX_CNT_EN
  function automatic logic [7:0] get_cnt(input int k);
    case (k)
      0: get_cnt = bus.cnt0;
      1: get_cnt = bus.cnt1;
      2: get_cnt = bus.cnt2;
      default: get_cnt = bus.cnt3;
    endcase
  endfunction
`endif

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      last_d[k] = '0;
      mcnt[k]   = 0;
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, then advance model at posedge.
  task automatic step(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                      input logic [3:0] yr, output logic acc);
    logic       exp_rdy;
    logic [3:0] exp_vld;
    @(negedge clk);
    bus.i_valid = v;
    bus.sel     = s;
    bus.i       = d;
    bus.y_ready = yr;
    #1;
    exp_rdy = (mq[s].size() == 0) || yr[s];
    check_val("i_ready", 32'(bus.i_ready), 32'(exp_rdy));
    for (int k = 0; k < 4; k++) exp_vld[k] = (mq[k].size() != 0);
    check_val("y_valid", 32'(bus.y_valid), 32'(exp_vld));
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("y%0d", k), 32'(get_y(k)),
                32'((mq[k].size() != 0) ? mq[k][0] : last_d[k]));
`ifdef DEMUX_CNT_EN
      check_val($sformatf("cnt%0d", k), 32'(get_cnt(k)), 32'(mcnt[k]));
`endif
    end
    @(posedge clk);
    acc = v & exp_rdy;
    for (int k = 0; k < 4; k++) begin
      if (mq[k].size() != 0 && yr[k]) begin
        last_d[k] = mq[k].pop_front();
        mcnt[k]   = (mcnt[k] + 1) % 256;
      end
    end
    if (acc) begin
      mq[s].push_back(d);
      last_d[s] = d;
    end
  endtask

  logic       acc;
  logic       pend_v;
  logic [1:0] pend_s;
  logic [W-1:0] pend_d;
  logic [W-1:0] sweep_d [4];

  initial begin
    sweep_d[0] = 3'b000; sweep_d[1] = 3'b100; sweep_d[2] = 3'b010; sweep_d[3] = 3'b001;
    bus.i_valid = 1'b0;
    bus.sel     = 2'd0;
    bus.i       = '0;
    bus.y_ready = 4'b0000;
    rst = 1'b1;
    model_reset();
    #12;
    check_val("rst_vld", 32'(bus.y_valid), 32'd0);
    check_val("rst_y0", 32'(bus.y0), 32'd0);
    check_val("rst_y3", 32'(bus.y3), 32'd0);
    check_val("rst_rdy", 32'(bus.i_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 2'd0, 3'd0, 4'b0000, acc);
    step(1'b0, 2'd0, 3'd0, 4'b0000, acc);

    // Single routing
    step(1'b1, 2'd1, 3'b100, 4'b1111, acc);
    #1;
    check_val("single_vld", 32'(bus.y_valid), 32'b0010);
    check_val("single_y1", 32'(bus.y1), 32'b100);
    step(1'b0, 2'd0, 3'd0, 4'b1111, acc);
    #1;
    check_val("single_gone", 32'(bus.y_valid), 32'b0000);

    // Sweep all four destinations
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 2'(k), sweep_d[k], 4'b1111, acc);
      check_val("sweep_acc", 32'(acc), 32'd1);
    end
    step(1'b0, 2'd0, 3'd0, 4'b1111, acc);
    step(1'b0, 2'd0, 3'd0, 4'b1111, acc);

    // Backpressure on output 2
    step(1'b1, 2'd2, 3'b010, 4'b1011, acc);
    check_val("bp_first_acc", 32'(acc), 32'd1);
    step(1'b1, 2'd2, 3'b011, 4'b1011, acc);
    check_val("bp_stall_acc", 32'(acc), 32'd0);
    step(1'b1, 2'd3, 3'b001, 4'b1011, acc);
    check_val("bp_other_acc", 32'(acc), 32'd1);
    step(1'b1, 2'd2, 3'b011, 4'b1111, acc);
    check_val("bp_release_acc", 32'(acc), 32'd1);
    #1;
    check_val("bp_second_y2", 32'(bus.y2), 32'b011);
    step(1'b0, 2'd0, 3'd0, 4'b1111, acc);

    // Back-to-back stream into output 0
    for (int j = 0; j < 5; j++) begin
      step(1'b1, 2'd0, 3'(j + 3), 4'b0001, acc);
      #1;
      check_val("stream_vld0", 32'(bus.y_valid[0]), 32'd1);
    end
    step(1'b0, 2'd0, 3'd0, 4'b1111, acc);

    // Fill all outputs, then assert reset between clock edges
    for (int k = 0; k < 4; k++) step(1'b1, 2'(k), 3'(k + 1), 4'b0000, acc);
    @(negedge clk);
    bus.i_valid = 1'b0;
    #1;
    check_val("full_before_rst", 32'(bus.y_valid), 32'b1111);
    #1;
    rst = 1'b1;
    #1;
    check_val("async_rst_vld", 32'(bus.y_valid), 32'd0);
    check_val("async_rst_y1", 32'(bus.y1), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // One beat each to 0..2, then 256 beats to output 3 (counter wrap)
    for (int k = 0; k < 3; k++) step(1'b1, 2'(k), 3'd5, 4'b1111, acc);
    for (int j = 0; j < 256; j++) step(1'b1, 2'd3, 3'(j), 4'b1111, acc);
    step(1'b0, 2'd0, 3'd0, 4'b1111, acc);
    step(1'b0, 2'd0, 3'd0, 4'b1111, acc);
`ifdef DEMUX_CNT_EN
    check_val("wrap_cnt3", 32'(bus.cnt3), 32'd0);
    check_val("wrap_cnt0", 32'(bus.cnt0), 32'd1);
    check_val("wrap_cnt2", 32'(bus.cnt2), 32'd1);
`endif

    // Randomized traffic; producer holds a stalled beat until accepted
    pend_v = 1'b0;
    pend_s = 2'd0;
    pend_d = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!pend_v) begin
        pend_v = ($urandom_range(0, 9) < 7);
        pend_s = 2'($urandom_range(0, 3));
        pend_d = W'($urandom);
      end
      step(pend_v, pend_s, pend_d, 4'($urandom), acc);
      if (acc) pend_v = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
